// File: rtl/core_rf_pkg.sv
// Shared register-file geometry, index/counter types and well-known register numbers.
package core_rf_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned IW    = $clog2(NREGS);
    localparam int unsigned CNTW  = 2;

    localparam int unsigned RAX    = 0;
    localparam int unsigned RDX    = 2;
    localparam int unsigned SP_IDX = 4;

    localparam logic [XLEN-1:0] SP_RESET = 64'h7C00;

    typedef logic [IW-1:0]   reg_idx_t;
    typedef logic [CNTW-1:0] pend_cnt_t;

    // Largest number of in-flight writers a single counter can track.
    localparam int PEND_MAX = (1 << CNTW) - 1;

endpackage

// File: rtl/sb_pend_counter.sv
// Pending-writer counter for one architectural register.
module sb_pend_counter
    import core_rf_pkg::*;
#(
    parameter int unsigned INCW = 2,
    parameter int unsigned DECW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [INCW-1:0] inc,
    input  logic [DECW-1:0] dec,
    input  logic            flush,
    output pend_cnt_t       count,
    output logic            busy,
    output logic            underflow
);

    pend_cnt_t cnt_q, cnt_d;
    int        sum;

    // Single adder for all same-cycle events; flush drops the increments.
    always_comb begin
        sum = int'(cnt_q) - int'(dec);
        if (!flush) begin
            sum = sum + int'(inc);
        end
        underflow = (sum < 0);
        if (flush || (sum < 0)) begin
            cnt_d = '0;
        end else if (sum > PEND_MAX) begin
            cnt_d = pend_cnt_t'(PEND_MAX);
        end else begin
            cnt_d = pend_cnt_t'(sum);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign busy  = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR file with per-register pending-writer scoreboard, writeback bypass and flush.
module regfile_scoreboard
    import core_rf_pkg::*;
#(
    parameter int unsigned NRD  = 3,
    parameter int unsigned NDST = 2,
    parameter int unsigned NWR  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                iss_valid,
    input  logic [NRD-1:0]      iss_src_v,
    input  logic [NRD*IW-1:0]   iss_src_idx,
    input  logic [NDST-1:0]     iss_dst_v,
    input  logic [NDST*IW-1:0]  iss_dst_idx,
    output logic                iss_ready,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wb_valid,
    input  logic [NWR*IW-1:0]   wb_idx,
    input  logic [NWR*XLEN-1:0] wb_data,
    input  logic [NWR-1:0]      wb_release,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_mask,
    output logic                err_underflow
);

    localparam int unsigned INCW = $clog2(NDST + 1);
    localparam int unsigned DECW = $clog2(NWR + 1);

    logic [XLEN-1:0] regs_q [NREGS];
    pend_cnt_t       pend   [NREGS];
    logic [INCW-1:0] inc    [NREGS];
    logic [DECW-1:0] dec    [NREGS];
    logic [NREGS-1:0] underflow;
    logic            fire;
    logic            err_q;

    // Releases per register this cycle; also used to compute effective pending.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            dec[i] = '0;
            for (int p = 0; p < int'(NWR); p++) begin
                if (wb_valid[p] && wb_release[p] && (wb_idx[p*IW +: IW] == reg_idx_t'(i))) begin
                    dec[i] = dec[i] + DECW'(1);
                end
            end
        end
    end

    // Issue readiness: sources must be net-free, destinations must have counter headroom.
    always_comb begin
        iss_ready = 1'b1;
        for (int k = 0; k < int'(NRD); k++) begin
            if (iss_src_v[k] && (32'(iss_src_idx[k*IW +: IW]) < NREGS)) begin
                if (int'(pend[iss_src_idx[k*IW +: IW]]) > int'(dec[iss_src_idx[k*IW +: IW]])) begin
                    iss_ready = 1'b0;
                end
            end
        end
        for (int d = 0; d < int'(NDST); d++) begin
            if (iss_dst_v[d] && (32'(iss_dst_idx[d*IW +: IW]) < NREGS)) begin
                if (int'(pend[iss_dst_idx[d*IW +: IW]]) >= PEND_MAX) begin
                    iss_ready = 1'b0;
                end
            end
        end
    end

    assign fire = iss_valid && iss_ready && !flush;

    // New writers per register from a firing issue; duplicate slots count twice.
    always_comb begin
        for (int i = 0; i < int'(NREGS); i++) begin
            inc[i] = '0;
            for (int d = 0; d < int'(NDST); d++) begin
                if (fire && iss_dst_v[d] && (iss_dst_idx[d*IW +: IW] == reg_idx_t'(i))) begin
                    inc[i] = inc[i] + INCW'(1);
                end
            end
        end
    end

    // Source read with bypass; later (higher) ports override earlier ones.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < int'(NRD); k++) begin
            if (32'(iss_src_idx[k*IW +: IW]) < NREGS) begin
                rd_data[k*XLEN +: XLEN] = regs_q[iss_src_idx[k*IW +: IW]];
            end
            for (int p = 0; p < int'(NWR); p++) begin
                if (wb_valid[p] && (wb_idx[p*IW +: IW] == iss_src_idx[k*IW +: IW])) begin
                    rd_data[k*XLEN +: XLEN] = wb_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Register array; highest-numbered writeback port wins a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= (i == int'(SP_IDX)) ? SP_RESET : '0;
            end
        end else begin
            for (int p = 0; p < int'(NWR); p++) begin
                if (wb_valid[p] && (32'(wb_idx[p*IW +: IW]) < NREGS)) begin
                    regs_q[wb_idx[p*IW +: IW]] <= wb_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NREGS); g++) begin : g_pend
        sb_pend_counter #(
            .INCW (INCW),
            .DECW (DECW)
        ) u_cnt (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (inc[g]),
            .dec       (dec[g]),
            .flush     (flush),
            .count     (pend[g]),
            .busy      (busy_mask[g]),
            .underflow (underflow[g])
        );
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (|underflow) begin
            err_q <= 1'b1;
        end
    end

    assign err_underflow = err_q;

endmodule
